// File: rtl/soc_debug_pkg.sv
// -----------------------------------------------------------------------------
// soc_debug_pkg
// Shared types for the CPU debug-channel arbiter:
//   - op_t        : 3-bit debug action code (bit index into take_action)
//   - DEBUG_JDO_W : width of the jdo debug command
//   - state_t     : arbiter FSM states
// -----------------------------------------------------------------------------
package soc_debug_pkg;

  localparam int DEBUG_JDO_W = 38;

  typedef enum logic [2:0] {
    OP_BREAK_A    = 3'd0,
    OP_BREAK_B    = 3'd1,
    OP_BREAK_C    = 3'd2,
    OP_OCIMEM_A   = 3'd3,
    OP_OCIMEM_B   = 3'd4,
    OP_TRACECTRL  = 3'd5,
    OP_TRACEMEM_A = 3'd6,
    OP_TRACEMEM_B = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/soc_debug_channel_arbiter_if.sv
// -----------------------------------------------------------------------------
// soc_debug_channel_arbiter_if
// Requester-side bus of the debug-channel arbiter.
//   req      : per-requester request level
//   req_cmd  : per-requester command, slice i = [i*DATA_W +: DATA_W]
//   req_op   : per-requester action code, slice i = [i*3 +: 3]
//   gnt      : one-hot grant, held for the whole transaction
//   done     : one-cycle completion pulse to the granted requester
//   rsp_data : response data, valid while done is high
//   rsp_err  : error flag, valid while done is high
// master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface soc_debug_channel_arbiter_if
  import soc_debug_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DEBUG_JDO_W
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_cmd;
  logic [N_REQ*3-1:0]      req_op;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [31:0]             rsp_data;
  logic                    rsp_err;

  modport master (
    output req, req_cmd, req_op,
    input  gnt, done, rsp_data, rsp_err
  );

  modport slave (
    input  req, req_cmd, req_op,
    output gnt, done, rsp_data, rsp_err
  );
endinterface

// File: rtl/soc_debug_rr_pick.sv
// -----------------------------------------------------------------------------
// soc_debug_rr_pick
// Combinational round-robin picker: searches req_i starting at ptr_i
// (ptr, ptr+1, ... mod N_REQ) and returns the first set requester.
//   req_i : request vector
//   ptr_i : search start index
//   win_o : one-hot winner (0 when no request)
//   idx_o : winner index
//   any_o : at least one request present
// -----------------------------------------------------------------------------
module soc_debug_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int pos;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    win_o = '0;
    idx_o = '0;
    pos   = 0;
    any_o = |req_i;
    // Scan farthest-to-nearest so the candidate closest to ptr, visited last,
    // overrides any earlier hit.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = (int'(ptr_i) + k) % N_REQ;
      if (req_i[pos]) begin
        win_o      = '0;
        win_o[pos] = 1'b1;
        idx_o      = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/soc_debug_channel_arbiter.sv
// -----------------------------------------------------------------------------
// soc_debug_channel_arbiter
// Shares one CPU debug-module command channel among N_REQ requesters. One
// transaction at a time: grant (round-robin), issue jdo + one-hot take_action,
// wait for monitor_ready or timeout, return MonDReg/error with a done pulse.
//   clk, reset_n  : CPU clock, synchronous active-low reset
//   bus (slave)   : requester bus (req/req_cmd/req_op -> gnt/done/rsp_*)
//   busy          : FSM not in IDLE
//   jdo           : registered command to the debug module
//   take_action   : one-hot action pulse, bit index = op
//   monitor_ready : debug monitor completion (only honoured in WAIT)
//   monitor_error : debug monitor error, sampled with monitor_ready
//   MonDReg       : debug monitor data register
// All outputs are registered.
// -----------------------------------------------------------------------------
module soc_debug_channel_arbiter
  import soc_debug_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DEBUG_JDO_W,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  soc_debug_channel_arbiter_if.slave bus,
  output logic                      busy,
  output logic [DATA_W-1:0]         jdo,
  output logic [7:0]                take_action,
  input  logic                      monitor_ready,
  input  logic                      monitor_error,
  input  logic [31:0]               MonDReg
);

  localparam int PTR_W = $clog2(N_REQ);

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    idx_q, idx_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [DATA_W-1:0]   jdo_q, jdo_d;
  logic [7:0]          take_q, take_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q;

  logic [N_REQ-1:0]    pick_win;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  op_t                 pick_op;
  logic                timeout;

  soc_debug_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign pick_op = op_t'(bus.req_op[pick_idx*3 +: 3]);
  assign timeout = (cnt_q == 8'(TIMEOUT - 1));

  // State register.
  // NOTE: reset is sampled inside the clocked block, so it only acts on an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (monitor_ready || timeout) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values. take_action and done are pulses, so they
  // default to zero; everything else holds.
  always_comb begin
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    jdo_d      = jdo_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    take_d     = '0;
    done_d     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d  = pick_win;
          idx_d  = pick_idx;
          jdo_d  = bus.req_cmd[pick_idx*DATA_W +: DATA_W];
          take_d = 8'b1 << pick_op;
        end
      end
      ST_ISSUE: cnt_d = '0;
      ST_WAIT: begin
        // Ready is checked first so it beats a coincident timeout.
        if (monitor_ready) begin
          rsp_data_d = MonDReg;
          rsp_err_d  = monitor_error;
          done_d     = gnt_q;
        end else if (timeout) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          done_d     = gnt_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        gnt_d = '0;
        ptr_d = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      jdo_q      <= '0;
      take_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      jdo_q      <= jdo_d;
      take_q     <= take_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;
  assign busy         = busy_q;
  assign jdo          = jdo_q;
  assign take_action  = take_q;

endmodule
